hdmi_downscaler: RTL and testbench
==================================

HDMI_DOWNSCALER -- requirements
Module: hdmi_downscaler

Interface
REQ-001 SHALL have parameter OSCREEN_WIDTH, default 72: visible HDMI pixels per line.
REQ-002 SHALL have parameter OSCREEN_HEIGHT, default 48: visible HDMI lines per frame.
REQ-003 SHALL have parameter SUB_X, default 2: horizontal decimation factor, power of two, 1..8.
REQ-004 SHALL have parameter SUB_Y, default 2: vertical decimation factor, power of two, 1..8.
REQ-005 SHALL have parameter FIFO_DEPTH, default 8: output FIFO entries, power of two.
REQ-006 SHALL have port clk_h  input  1  HDMI pixel clock; the only clock.
REQ-007 SHALL have port rst_h_n  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port hx  input  10  HDMI raster column, advances one per clk_h.
REQ-009 SHALL have port hy  input  10  HDMI raster line.
REQ-010 SHALL have port rgb_h  input  24  HDMI pixel {R,G,B}, aligned with hx/hy.
REQ-011 SHALL have port dx  output  9  downscaled column.
REQ-012 SHALL have port dy  output  9  downscaled line.
REQ-013 SHALL have port rgb_d  output  24  downscaled pixel {R,G,B}.
REQ-014 SHALL have port d_valid  output  1  FIFO head holds a pixel.
REQ-015 SHALL have port d_ready  input  1  consumer accepts the head.
REQ-016 SHALL have port overflow  output  1  sticky flag: a pixel was dropped.

Function
REQ-017 SHALL treat an input as visible only when hx<OSCREEN_WIDTH and hy<OSCREEN_HEIGHT; all other inputs are ignored.
REQ-018 SHALL map visible (hx,hy) to block (hx/SUB_X, hy/SUB_Y); output size is OSCREEN_WIDTH/SUB_X by OSCREEN_HEIGHT/SUB_Y.
REQ-019 SHALL stop elaboration with an error if OSCREEN_WIDTH%SUB_X or OSCREEN_HEIGHT%SUB_Y is nonzero.
REQ-020 SHALL keep per-channel accumulators 8+log2(SUB_X*SUB_Y) bits wide, so no sum ever overflows.
REQ-021 SHALL load the horizontal accumulator when hx%SUB_X==0, and add to it on the other visible columns.
REQ-022 SHALL, when hx%SUB_X==SUB_X-1, combine the horizontal sum with the line-buffer entry at index hx/SUB_X.
REQ-023 SHALL perform that combine as follows: write the sum when hy%SUB_Y==0; write entry plus sum on the other lines.
REQ-024 SHALL, on hy%SUB_Y==SUB_Y-1, push {hx/SUB_X, hy/SUB_Y, total>>log2(SUB_X*SUB_Y)} into the FIFO; the shift truncates.
REQ-025 SHALL make the push visible on d_valid exactly 2 clk_h cycles after the last contributing input pixel, when the FIFO was empty.
REQ-026 SHALL pop the FIFO head on any cycle where d_valid and d_ready are both high; dx/dy/rgb_d SHALL stay stable while d_valid=1 and d_ready=0.
REQ-027 SHALL, on a push into a full FIFO with no pop in the same cycle, drop the new pixel and set overflow to 1.
REQ-028 SHALL, on a simultaneous push and pop into a full FIFO, accept both; the count is unchanged and overflow is not set.
REQ-029 SHALL restart block accumulation on hy wrap-around (new frame) without any flush; partial data from an interrupted frame is overwritten.
REQ-030 SHALL ignore d_ready while d_valid=0.

Reset
REQ-031 SHALL, with rst_h_n=0 at a clk_h edge, clear d_valid, overflow, FIFO pointers and count, and the accumulators.
REQ-032 SHALL drive dx=0, dy=0, rgb_d=0 during reset; line-buffer contents need not be cleared.
REQ-033 SHALL discard queued data and partial sums on reset asserted mid-frame; after release, the first valid output is the first complete block.

Configuration
REQ-034 SHALL, with macro HDMI_DOWNSCALER_AVG_EN defined, produce box-average output per REQ-020..REQ-024.
REQ-035 SHALL, without HDMI_DOWNSCALER_AVG_EN, point-sample: the pixel at hx%SUB_X==0, hy%SUB_Y==0 is pushed directly, with no line buffer or accumulators, same 2-cycle latency.

Verification
REQ-036 SHALL cover: constant rgb_h=24'h336699 with d_ready=1 -> 36x24 outputs per frame, all 24'h336699, dx/dy raster ordered.
REQ-037 SHALL cover: a 2x2 block of 24'h000000, 24'h030303, 24'h000000, 24'h020202 -> 24'h010101 with AVG_EN (5/4 truncated); 24'h000000 without it.
REQ-038 SHALL cover: d_ready=0 for one full block row (36 pushes) with FIFO_DEPTH=8 -> 8 entries retained, overflow=1, 28 dropped, order preserved on drain.
REQ-039 SHALL cover: FIFO full with d_ready=1 on a push cycle -> count stays 8, overflow stays 0.
REQ-040 SHALL cover: rst_h_n pulsed low for 1 cycle at hy=11 -> d_valid=0 next cycle, overflow=0, first output afterward is dy=6, dx=0.
REQ-041 SHALL cover: back-to-back frames at hy wrap -> the frame-2 output for block (0,0) is independent of frame-1 data.

Source files
------------

// File: rtl/hdmi_downscaler.sv
// HDMI raster downscaler: decimates visible pixels into SUB_X x SUB_Y blocks and queues them in an output FIFO.
// Define HDMI_DOWNSCALER_AVG_EN for box averaging; without it the top-left pixel of each block is sampled.
module hdmi_downscaler #(
    parameter int OSCREEN_WIDTH  = 72,
    parameter int OSCREEN_HEIGHT = 48,
    parameter int SUB_X          = 2,
    parameter int SUB_Y          = 2,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic        clk_h,
    input  logic        rst_h_n,
    input  logic [9:0]  hx,
    input  logic [9:0]  hy,
    input  logic [23:0] rgb_h,
    output logic [8:0]  dx,
    output logic [8:0]  dy,
    output logic [23:0] rgb_d,
    output logic        d_valid,
    input  logic        d_ready,
    output logic        overflow
);

    localparam int LX  = $clog2(SUB_X);
    localparam int LY  = $clog2(SUB_Y);
    localparam int LXY = LX + LY;
    localparam int AW  = 8 + LXY;
    localparam int OW  = OSCREEN_WIDTH / SUB_X;
    localparam int IW  = (OW > 1) ? $clog2(OW) : 1;
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = PW + 1;
    localparam int FW  = 42;
    localparam logic [9:0] MX = 10'(SUB_X - 1);
    localparam logic [9:0] MY = 10'(SUB_Y - 1);

    if ((OSCREEN_WIDTH % SUB_X) != 0 || (OSCREEN_HEIGHT % SUB_Y) != 0) begin : g_bad_size
        $error("hdmi_downscaler: screen size must be a multiple of the decimation factors");
    end

    logic visible, first_col, first_row, arm_now, take;
    logic armed_reg;

    assign visible   = (hx < 10'(OSCREEN_WIDTH)) && (hy < 10'(OSCREEN_HEIGHT));
    assign first_col = (hx & MX) == 10'd0;
    assign first_row = (hy & MY) == 10'd0;
    // Accumulation only starts at the top-left of a block row, so a reset mid-frame never emits partial blocks.
    assign arm_now   = visible && (hx == 10'd0) && first_row;
    assign take      = visible && (armed_reg || arm_now);

    always_ff @(posedge clk_h) begin
        if (!rst_h_n) begin
            armed_reg <= 1'b0;
        end else if (arm_now) begin
            armed_reg <= 1'b1;
        end
    end

    logic        s1_push_reg;
    logic [8:0]  s1_dx_reg, s1_dy_reg;
    logic [23:0] push_rgb;

    always_ff @(posedge clk_h) begin
        if (!rst_h_n) begin
            s1_dx_reg <= 9'd0;
            s1_dy_reg <= 9'd0;
        end else begin
            s1_dx_reg <= 9'(hx >> LX);
            s1_dy_reg <= 9'(hy >> LY);
        end
    end

`ifdef HDMI_DOWNSCALER_AVG_EN
    logic last_col, last_row;
    logic s1_comb_reg, s1_first_row_reg;

    assign last_col = (hx & MX) == MX;
    assign last_row = (hy & MY) == MY;

    always_ff @(posedge clk_h) begin
        if (!rst_h_n) begin
            s1_comb_reg      <= 1'b0;
            s1_push_reg      <= 1'b0;
            s1_first_row_reg <= 1'b0;
        end else begin
            s1_comb_reg      <= take && last_col;
            s1_push_reg      <= take && last_col && last_row;
            s1_first_row_reg <= first_row;
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        logic [7:0]    pix;
        logic [AW-1:0] hsum, total;
        logic [AW-1:0] hacc_reg, s1_sum_reg, lb_rd_reg;
        logic [AW-1:0] lb_mem [2**IW];

        assign pix   = rgb_h[gi*8 +: 8];
        assign hsum  = first_col ? AW'(pix) : hacc_reg + AW'(pix);
        assign total = s1_first_row_reg ? s1_sum_reg : lb_rd_reg + s1_sum_reg;
        assign push_rgb[gi*8 +: 8] = 8'(total >> LXY);

        always_ff @(posedge clk_h) begin
            if (!rst_h_n) begin
                hacc_reg   <= '0;
                s1_sum_reg <= '0;
            end else if (take) begin
                hacc_reg   <= hsum;
                s1_sum_reg <= hsum;
            end
        end

        // Read of entry k is issued one cycle before its write-back, and the next read of k is a line later.
        always_ff @(posedge clk_h) begin
            if (take && last_col) begin
                lb_rd_reg <= lb_mem[IW'(hx >> LX)];
            end
            if (s1_comb_reg) begin
                lb_mem[IW'(s1_dx_reg)] <= total;
            end
        end
    end
`else
    logic [23:0] s1_rgb_reg;

    always_ff @(posedge clk_h) begin
        if (!rst_h_n) begin
            s1_push_reg <= 1'b0;
            s1_rgb_reg  <= 24'd0;
        end else begin
            s1_push_reg <= take && first_col && first_row;
            s1_rgb_reg  <= rgb_h;
        end
    end

    assign push_rgb = s1_rgb_reg;
`endif

    logic [FW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          overflow_reg;
    logic          full, pop, accept;
    logic [FW-1:0] head;

    assign full   = count_reg == CW'(FIFO_DEPTH);
    assign pop    = d_valid && d_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign accept = s1_push_reg && (!full || pop);

    always_ff @(posedge clk_h) begin
        if (accept) begin
            fifo_mem[wr_ptr_reg] <= {s1_dx_reg, s1_dy_reg, push_rgb};
        end
    end

    always_ff @(posedge clk_h) begin
        if (!rst_h_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (accept && !pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (!accept && pop) begin
                count_reg <= count_reg - CW'(1);
            end
            if (s1_push_reg && full && !pop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign head            = fifo_mem[rd_ptr_reg];
    assign d_valid         = count_reg != '0;
    assign overflow        = overflow_reg;
    assign {dx, dy, rgb_d} = d_valid ? head : '0;

endmodule

// File: tb/tb_hdmi_downscaler.sv
// Scoreboard bench for hdmi_downscaler: raster stimulus queues expected blocks, a negedge monitor pops and compares.
module tb_hdmi_downscaler;

    localparam int W     = 72;
    localparam int H     = 48;
    localparam int LINE  = 80;
    localparam int LINES = 50;
`ifdef HDMI_DOWNSCALER_AVG_EN
    localparam int          OFF     = 1;
    localparam logic [23:0] PAT_EXP = 24'h010101;
`else
    localparam int          OFF     = 0;
    localparam logic [23:0] PAT_EXP = 24'h000000;
`endif

    logic        clk_h = 1'b0;
    logic        rst_h_n = 1'b0;
    logic [9:0]  hx = 10'h3ff;
    logic [9:0]  hy = 10'h3ff;
    logic [23:0] rgb_h = 24'd0;
    logic        d_ready = 1'b1;
    logic [8:0]  dx, dy;
    logic [23:0] rgb_d;
    logic        d_valid, overflow;

    hdmi_downscaler #(
        .OSCREEN_WIDTH(W), .OSCREEN_HEIGHT(H), .SUB_X(2), .SUB_Y(2), .FIFO_DEPTH(8)
    ) dut (
        .clk_h(clk_h), .rst_h_n(rst_h_n), .hx(hx), .hy(hy), .rgb_h(rgb_h),
        .dx(dx), .dy(dy), .rgb_d(rgb_d), .d_valid(d_valid), .d_ready(d_ready),
        .overflow(overflow)
    );

    always #5 clk_h = ~clk_h;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_out = 0;
    int          keep_left = 100000;
    bit          expect_en = 1'b1;
    bit          pat_en = 1'b0;
    bit          lat_chk = 1'b0;
    bit          lat_pending = 1'b0;
    bit          cap_first = 1'b0;
    logic [41:0] first_out = '0;
    logic [41:0] mon_e;
    logic [41:0] held = '0;
    logic        stall_prev = 1'b0;
    logic [41:0] exp_q[$];

    task automatic check(input string name, input logic [41:0] act, input logic [41:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        check(name, {41'b0, act}, {41'b0, req});
    endtask

    function automatic logic [23:0] pix(input int x, input int y);
        if (pat_en && x < 2 && y < 2) begin
            if (x == 1 && y == 0) return 24'h030303;
            if (x == 1 && y == 1) return 24'h020202;
            return 24'h000000;
        end
        return 24'h336699;
    endfunction

    task automatic px(input int x, input int y);
        hx    = 10'(x);
        hy    = 10'(y);
        rgb_h = pix(x, y);
        @(posedge clk_h);
        #1;
    endtask

    task automatic blank(input int n);
        repeat (n) px(1023, 1023);
    endtask

    task automatic run_span(input int y, input int x0, input int x1);
        for (int x = x0; x < x1; x++) begin
            bit trig;
            trig = (x < W) && (y < H) && (x % 2 == OFF) && (y % 2 == OFF);
            if (trig && expect_en && keep_left > 0) begin
                exp_q.push_back({9'(x / 2), 9'(y / 2),
                                 (pat_en && x < 2 && y < 2) ? PAT_EXP : 24'h336699});
                keep_left--;
            end
            px(x, y);
            if (lat_pending) begin
                check1("latency_2cyc", d_valid, 1'b1);
                lat_pending = 1'b0;
            end
            if (lat_chk && trig && x < 2 && y < 2) begin
                check1("latency_not_1cyc", d_valid, 1'b0);
                lat_pending = 1'b1;
                lat_chk     = 1'b0;
            end
        end
    endtask

    task automatic run_rows(input int y0, input int y1);
        for (int y = y0; y < y1; y++) run_span(y, 0, LINE);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            px(1023, 1023);
            t++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: %0d outputs still pending, required 0", exp_q.size());
        end
    endtask

    always @(negedge clk_h) begin
        if (rst_h_n && d_valid) begin
            if (stall_prev) check("hold_while_stalled", {dx, dy, rgb_d}, held);
            if (d_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got %h, required none", {dx, dy, rgb_d});
                end else begin
                    mon_e = exp_q.pop_front();
                    check("output", {dx, dy, rgb_d}, mon_e);
                    n_out++;
                    if (cap_first) begin
                        first_out = {dx, dy, rgb_d};
                        cap_first = 1'b0;
                    end
                end
            end
        end
        stall_prev = rst_h_n && d_valid && !d_ready;
        held       = {dx, dy, rgb_d};
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk_h);
        #1;
        check1("rst_d_valid", d_valid, 1'b0);
        check1("rst_overflow", overflow, 1'b0);
        check("rst_outputs", {dx, dy, rgb_d}, 42'd0);
        rst_h_n = 1'b1;

        // Constant colour frame, consumer always ready.
        n_out = 0;
        run_rows(0, LINES);
        wait_drain();
        check("frame_out_count", 42'(n_out), 42'd864);
        check1("frame_no_overflow", overflow, 1'b0);

        // Consumer stalled for a whole block row: first 8 kept, rest dropped.
        d_ready   = 1'b0;
        keep_left = 8;
        run_rows(0, 2);
        blank(4);
        check1("stall_overflow_set", overflow, 1'b1);
        check1("stall_valid", d_valid, 1'b1);
        d_ready   = 1'b1;
        keep_left = 100000;
        wait_drain();
        blank(4);
        check1("stall_drained_empty", d_valid, 1'b0);
        rst_h_n = 1'b0;
        blank(1);
        rst_h_n = 1'b1;
        check1("overflow_cleared", overflow, 1'b0);

        // Full FIFO with a pop exactly on the push cycle of block 8.
        d_ready = 1'b0;
        run_rows(0, OFF);
        run_span(OFF, 0, 17 + OFF);
        d_ready = 1'b1;
        run_span(OFF, 17 + OFF, 18 + OFF);
        d_ready = 1'b0;
        blank(4);
        check1("full_pushpop_no_overflow", overflow, 1'b0);
        check1("full_valid", d_valid, 1'b1);
        d_ready = 1'b1;
        wait_drain();
        blank(2);
        check1("full_drained_empty", d_valid, 1'b0);
        check1("full_overflow_final", overflow, 1'b0);

        // Reset pulse mid-frame at hy=11.
        run_rows(0, 11);
        run_span(11, 0, 20);
        rst_h_n = 1'b0;
        px(20, 11);
        rst_h_n = 1'b1;
        exp_q.delete();
        cap_first = 1'b1;
        check1("rst_mid_valid", d_valid, 1'b0);
        check1("rst_mid_overflow", overflow, 1'b0);
        expect_en = 1'b0;
        run_span(11, 21, LINE);
        expect_en = 1'b1;
        run_rows(12, LINES);
        wait_drain();
        check("first_after_rst", {24'b0, first_out[41:24]}, {24'b0, 9'd0, 9'd6});

        // Next frame straight after: block (0,0) uses the pattern, independent of earlier data.
        pat_en    = 1'b1;
        lat_chk   = 1'b1;
        cap_first = 1'b1;
        run_rows(0, LINES);
        pat_en = 1'b0;
        wait_drain();
        check("frame2_block00", first_out, {9'd0, 9'd0, PAT_EXP});
        check1("final_overflow", overflow, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
